// File: rtl/cnna_mul_share_arb.sv
// ============================================================================
//  Module   : cnna_mul_share_arb
//  Brief    : Round-robin arbiter sharing one 10b-unsigned x 16b-signed
//             multiplier between NUM_REQ requesters, one registered result.
//             Optional macro CNNA_MUL_ARB_CONTENTION_CNT_EN adds a saturating
//             contention counter output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnna_mul_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*10-1:0]   req_a,
   input  logic [NUM_REQ*16-1:0]   req_b,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [ID_W-1:0]         res_id,
`ifdef CNNA_MUL_ARB_CONTENTION_CNT_EN
   output logic [15:0]             contention_cnt,
`endif
   output logic signed [25:0]      res_p
);

   localparam int c_a_w = 10;
   localparam int c_b_w = 16;
   localparam int c_p_w = 26;

   logic                    r_res_valid;
   logic signed [c_p_w-1:0] r_res_p;
   logic [ID_W-1:0]         r_res_id;
   logic [ID_W-1:0]         r_rr_ptr;

   logic                    w_slot_free;
   logic                    w_any_valid;
   logic                    w_xfer;
   logic [ID_W-1:0]         w_grant_id;
   logic [ID_W-1:0]         w_next_ptr;
   logic [c_a_w-1:0]        w_a;
   logic [c_b_w-1:0]        w_b;
   logic signed [c_p_w-1:0] w_a_ext;
   logic signed [c_p_w-1:0] w_b_ext;
   logic signed [c_p_w-1:0] w_prod;
   int                      w_idx;

   assign w_slot_free = !r_res_valid || res_ready;
   assign w_xfer      = w_any_valid && w_slot_free;

   // Rotating search starting at r_rr_ptr; the first valid index found wins.
   always_comb begin
      w_idx       = 0;
      w_any_valid = 1'b0;
      w_grant_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         if (!w_any_valid && req_valid[w_idx]) begin
            w_any_valid = 1'b1;
            w_grant_id  = ID_W'(w_idx);
         end
      end
   end

   always_comb begin
      w_a       = '0;
      w_b       = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_id == ID_W'(i)) begin
            w_a          = req_a[i*c_a_w +: c_a_w];
            w_b          = req_b[i*c_b_w +: c_b_w];
            req_ready[i] = w_xfer && !ap_rst;
         end
      end
   end

   assign w_next_ptr = (int'(w_grant_id) == NUM_REQ-1) ? '0 : w_grant_id + ID_W'(1);

   // Operands widened to the full product width so the multiply is exact.
   assign w_a_ext = {{(c_p_w-c_a_w){1'b0}}, w_a};
   assign w_b_ext = {{(c_p_w-c_b_w){w_b[c_b_w-1]}}, w_b};
   assign w_prod  = w_a_ext * w_b_ext;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_res_valid <= 1'b0;
         r_res_p     <= '0;
         r_res_id    <= '0;
         r_rr_ptr    <= '0;
      end else if (w_xfer) begin
         r_res_valid <= 1'b1;
         r_res_p     <= w_prod;
         r_res_id    <= w_grant_id;
         r_rr_ptr    <= w_next_ptr;
      end else if (w_slot_free) begin
         r_res_valid <= 1'b0;
      end
   end

   assign res_valid = r_res_valid;
   assign res_p     = r_res_p;
   assign res_id    = r_res_id;

`ifdef CNNA_MUL_ARB_CONTENTION_CNT_EN
   logic [15:0] r_contention_cnt;
   logic        w_multi_valid;

   // Clearing the lowest set bit leaves something only if two or more are set.
   assign w_multi_valid = (req_valid & (req_valid - NUM_REQ'(1))) != '0;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_contention_cnt <= '0;
      end else if (w_slot_free && w_multi_valid && (r_contention_cnt != 16'hFFFF)) begin
         r_contention_cnt <= r_contention_cnt + 16'd1;
      end
   end

   assign contention_cnt = r_contention_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cnna_mul_share_arb.sv
// ============================================================================
//  Module   : tb_cnna_mul_share_arb
//  Brief    : Self-checking bench for cnna_mul_share_arb (model + directed).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnna_mul_share_arb;

   localparam int N = 4;

   logic                ap_clk = 1'b0;
   logic                ap_rst;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [N*10-1:0]     req_a;
   logic [N*16-1:0]     req_b;
   logic                res_valid;
   logic                res_ready;
   logic [1:0]          res_id;
   logic signed [25:0]  res_p;
`ifdef CNNA_MUL_ARB_CONTENTION_CNT_EN
   logic [15:0]         contention_cnt;
`endif

   logic [9:0]          a [N];
   logic signed [15:0]  b [N];

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   // Model state
   int     m_ptr;
   bit     m_valid;
   int     m_id;
   longint m_p;
   int     m_cnt;

   cnna_mul_share_arb #(.NUM_REQ(N), .ID_W(2)) dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
`ifdef CNNA_MUL_ARB_CONTENTION_CNT_EN
      .contention_cnt (contention_cnt),
`endif
      .res_p     (res_p)
   );

   always #5 ap_clk = ~ap_clk;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < N; i++) begin
         req_a[10*i +: 10] = a[i];
         req_b[16*i +: 16] = b[i];
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int model_grant();
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   always @(posedge ap_clk) begin : model
      int g;
      bit sf;
      if (ap_rst) begin
         m_ptr = 0; m_valid = 0; m_id = 0; m_p = 0; m_cnt = 0;
      end else begin
         sf = !m_valid || res_ready;
         g  = model_grant();
         if (sf && $countones(req_valid) >= 2 && m_cnt < 65535) m_cnt++;
         if (sf && g >= 0) begin
            m_p     = longint'(a[g]) * longint'(b[g]);
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % N;
         end else if (sf) begin
            m_valid = 0;
         end
      end
   end

   always @(negedge ap_clk) begin : compare
      int g;
      longint exp_ready;
      if (chk_on) begin
         g = model_grant();
         exp_ready = (ap_rst || !(!m_valid || res_ready) || g < 0) ? 0 : (longint'(1) << g);
         chk("cyc_req_ready", req_ready, exp_ready);
         chk("cyc_res_valid", res_valid, m_valid);
         chk("cyc_res_id", res_id, m_id);
         chk("cyc_res_p", res_p, m_p);
`ifdef CNNA_MUL_ARB_CONTENTION_CNT_EN
         chk("cyc_cnt", contention_cnt, m_cnt);
`endif
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   int     seq_id [4] = '{3, 1, 3, 1};
   longint seq_p  [4] = '{-35, 33520641, -35, 33520641};

   initial begin
      ap_rst    = 1'b1;
      req_valid = 4'hF;
      res_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         a[i] = 10'(100 * (i + 1));
         b[i] = 16'(-3 * (i + 1));
      end
      tick();
      tick();
      chk_on = 1'b1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_p", res_p, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_req_ready", req_ready, 0);

      // All valid: strict rotation from index 0
      ap_rst    = 1'b0;
      res_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr_id", res_id, k % 4);
         chk("rr_valid", res_valid, 1);
      end

      // Requesters 1 and 3 only, pointer now at 2
      req_valid = 4'b1010;
      a[1] = 10'd1023; b[1] = 16'sd32767;
      a[3] = 10'd5;    b[3] = -16'sd7;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("pair_id", res_id, seq_id[k]);
         chk("pair_p", res_p, seq_p[k]);
      end

      // Single requester with most negative product
      req_valid = 4'b0100;
      a[2] = 10'd1023; b[2] = -16'sd32768;
      #1;
      chk("single_ready", req_ready, 4'b0100);
      tick();
      chk("single_valid", res_valid, 1);
      chk("single_id", res_id, 2);
      chk("single_p", res_p, -33521664);
      chk("single_p_hex", longint'(unsigned'(res_p)), 26'h2008000);

      // Backpressure for 3 cycles
      res_ready = 1'b0;
      req_valid = 4'hF;
      #1;
      chk("stall_ready0", req_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_ready", req_ready, 0);
         chk("stall_id", res_id, 2);
         chk("stall_p", res_p, -33521664);
      end
      res_ready = 1'b1;
      #1;
      chk("unstall_ready", req_ready, 4'b1000);
      tick();
      chk("unstall_id", res_id, 3);

      // Advance pointer to 3 then reset mid-stream
      for (int k = 0; k < 3; k++) tick();
      chk("prerst_id", res_id, 2);
      ap_rst = 1'b1;
      #1;
      chk("inrst_ready", req_ready, 0);
      tick();
      chk("postrst_valid", res_valid, 0);
      chk("postrst_id", res_id, 0);
      chk("postrst_p", res_p, 0);
      ap_rst = 1'b0;
      #1;
      chk("postrst_ready", req_ready, 4'b0001);
      tick();
      chk("postrst_first_id", res_id, 0);

      // Idle cycle drops res_valid
      req_valid = 4'b0000;
      tick();
      chk("idle_valid", res_valid, 0);

`ifdef CNNA_MUL_ARB_CONTENTION_CNT_EN
      ap_rst = 1'b1;
      tick();
      ap_rst    = 1'b0;
      req_valid = 4'hF;
      for (int k = 0; k < 5; k++) tick();
      chk("cnt_five", contention_cnt, 5);
      force dut.r_contention_cnt = 16'hFFFF;
      m_cnt = 65535;
      tick();
      release dut.r_contention_cnt;
      tick();
      tick();
      chk("cnt_sat", contention_cnt, 16'hFFFF);
      req_valid = 4'b0000;
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cnna_mul_share_arb.md
CNNA_MUL_SHARE_ARB -- requirements
Module: cnna_mul_share_arb

Interface
REQ-001: Parameter NUM_REQ, default 4, is the number of requesters sharing one 10-bit-unsigned x 16-bit-signed multiplier; legal range 2..2**ID_W.
REQ-002: Parameter ID_W, default 2, is the width of the requester index.
REQ-003: ap_clk  in  1  single clock; all state updates on rising edge.
REQ-004: ap_rst  in  1  synchronous, active-high reset.
REQ-005: req_valid  in  NUM_REQ  per-requester operand-valid.
REQ-006: req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007: req_a  in  NUM_REQ*10  packed unsigned operands; requester i uses bits [10*i+9:10*i].
REQ-008: req_b  in  NUM_REQ*16  packed signed operands; requester i uses bits [16*i+15:16*i].
REQ-009: res_valid  out  1  registered result valid.
REQ-010: res_ready  in  1  downstream accept of the result.
REQ-011: res_id  out  ID_W  index of the requester that owns res_p.
REQ-012: res_p  out  26  signed product.

Function
REQ-013: slot_free = !res_valid || res_ready; the block SHALL accept a request only in a cycle where slot_free is 1.
REQ-014: Transfer on requester i occurs when req_valid[i] && req_ready[i] are both high.
REQ-015: Arbitration is round-robin, searching indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first valid index g wins.
REQ-016: req_ready[g] = slot_free; all other req_ready bits are 0. req_ready is combinational from req_valid, rr_ptr, res_valid and res_ready.
REQ-017: On transfer, at the next edge: res_p <= $signed({1'b0,a_g}) * $signed(b_g), full precision in 26 bits; res_id <= g; res_valid <= 1; rr_ptr <= (g+1) mod NUM_REQ.
REQ-018: If slot_free and no req_valid, then res_valid <= 0 at the next edge; rr_ptr, res_p and res_id hold.
REQ-019: While res_valid && !res_ready, res_p, res_id, res_valid and rr_ptr hold and all req_ready are 0.
REQ-020: Latency is 1 cycle from transfer to res_valid. Throughput is one product per cycle while res_ready is held high.
REQ-021: Fairness: a continuously valid requester is granted within NUM_REQ consecutive transfers.
REQ-022: Requesters hold a and b stable while valid and not ready, and do not make req_valid depend on req_ready.
REQ-023: Arithmetic range: the result spans -33521664 to 33520641; no saturation or truncation occurs.

Reset
REQ-024: When ap_rst=1 at an edge: res_valid <= 0, res_p <= 0, res_id <= 0, rr_ptr <= 0. Any in-flight result is discarded.
REQ-025: While ap_rst=1, all req_ready bits are 0, regardless of req_valid.

Configuration
REQ-026: Macro CNNA_MUL_ARB_CONTENTION_CNT_EN, when defined, adds output port contention_cnt (out, 16 bits).
REQ-027: contention_cnt increments by 1 on each edge where slot_free is 1 and two or more req_valid bits are high.
REQ-028: contention_cnt saturates at 0xFFFF and resets to 0 on ap_rst.
REQ-029: Without CNNA_MUL_ARB_CONTENTION_CNT_EN, the port and counter are absent, and all other behaviour is identical.

Verification
REQ-030: Only req_valid[2] high, a2=1023, b2=-32768, res_ready=1 -> req_ready=4'b0100; next cycle res_valid=1, res_id=2, res_p=26'h2008000 (-33521664).
REQ-031: All four requesters valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0,1 on consecutive cycles, with res_valid constantly 1.
REQ-032: Only requesters 1 and 3 valid, rr_ptr=2 -> grant sequence 3,1,3,1; requester 1 with a=1023, b=32767 yields res_p=33520641.
REQ-033: res_valid=1 and res_ready=0 for 3 cycles -> all req_ready=0 and res_p/res_id stable. When res_ready rises, a new transfer occurs in that same cycle.
REQ-034: ap_rst pulsed while res_valid=1 and rr_ptr=3 -> next cycle res_valid=0 and rr_ptr=0. With all requesters valid after reset, the first grant goes to requester 0.
REQ-035 (macro defined): all four requesters valid for 5 accepting cycles -> contention_cnt=5. Forced to 0xFFFF, it stays at 0xFFFF on further contention.
